// File: rtl/addsub_pkg.sv
// Shared types and constants for the sequential add/subtract unit.
// Holds the FSM state encoding, op encoding and the parameter-legality check.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // WIDTH must hold a sign bit plus magnitude, and split evenly into STEP-bit slices
  function automatic bit params_legal(input int width, input int step);
    return (width >= 2) && (step >= 1) && (step <= width) && ((width % step) == 0);
  endfunction

endpackage

// File: rtl/seq_addsub_unit_if.sv
// Request/result handshake bundle for seq_addsub_unit.
// The master drives operands and out_ready; the slave (the unit) drives results.
interface seq_addsub_unit_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Op;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] S;
  logic             Cout;
  logic             V;
  logic             Z;
  logic             N;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output A, B, Op, in_valid, out_ready,
    input  in_ready, S, Cout, V, Z, N, out_valid
  );

  modport slave (
    input  A, B, Op, in_valid, out_ready,
    output in_ready, S, Cout, V, Z, N, out_valid
  );
endinterface

// File: rtl/addsub_slice.sv
// Combinational STEP-bit ripple of full adders; sub inverts b (carry-in supplies the +1).
// cmsb is the carry into the slice MSB, used for signed-overflow detection.
module addsub_slice
  import addsub_pkg::*;
#(
  parameter int STEP = 1
) (
  input  logic [STEP-1:0] a,
  input  logic [STEP-1:0] b,
  input  logic            cin,
  input  logic            sub,
  output logic [STEP-1:0] s,
  output logic            cout,
  output logic            cmsb
);

  logic [STEP-1:0] bx_s;
  logic [STEP:0]   c_s;

  assign bx_s = (sub == OP_ADD) ? b : ~b;

  // Ripple carry through the slice
  always_comb begin
    c_s    = '0;
    s      = '0;
    c_s[0] = cin;
    for (int i = 0; i < STEP; i++) begin
      s[i]     = a[i] ^ bx_s[i] ^ c_s[i];
      c_s[i+1] = (a[i] & bx_s[i]) | (c_s[i] & (a[i] ^ bx_s[i]));
    end
  end

  assign cout = c_s[STEP];
  assign cmsb = c_s[STEP-1];

endmodule

// File: rtl/seq_addsub_unit.sv
// Sequential add/subtract: STEP bits per cycle, LSB first, K = WIDTH/STEP RUN cycles.
// Optional signed saturation on overflow when ADDSUB_SAT_EN is defined.
module seq_addsub_unit
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input logic               clk,
  input logic               rst_n,
  seq_addsub_unit_if.slave  bus
);

  localparam int K  = WIDTH / STEP;
  localparam int CW = (K > 1) ? $clog2(K) : 1;

  if (!params_legal(WIDTH, STEP)) begin : g_param_err
    $error("seq_addsub_unit: illegal WIDTH/STEP combination");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, acc_q;
  logic             op_q, carry_q, a_sign_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] s_q;
  logic             cout_q, v_q, z_q, n_q;

  logic             accept_s, last_s;
  logic [STEP-1:0]  sl_s;
  logic             sl_cout_s, sl_cmsb_s, v_next_s;
  logic [WIDTH+STEP-1:0] cat_s;
  logic [WIDTH-1:0] acc_next_s, res_s;

  assign accept_s = bus.in_valid && (state_q == IDLE);
  assign last_s   = (state_q == RUN) && (cnt_q == '0);

  addsub_slice #(.STEP(STEP)) u_slice (
    .a    (a_q[STEP-1:0]),
    .b    (b_q[STEP-1:0]),
    .cin  (carry_q),
    .sub  (op_q),
    .s    (sl_s),
    .cout (sl_cout_s),
    .cmsb (sl_cmsb_s)
  );

  // New slice enters at the top; after K cycles the first slice sits at bit 0
  assign cat_s      = {sl_s, acc_q};
  assign acc_next_s = cat_s[WIDTH+STEP-1:STEP];
  assign v_next_s   = sl_cout_s ^ sl_cmsb_s;

`ifdef ADDSUB_SAT_EN
  assign res_s = !v_next_s ? acc_next_s :
                 (a_sign_q ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}});
`else
  assign res_s = acc_next_s;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = accept_s ? RUN : IDLE;
      RUN:     state_d = last_s ? DONE : RUN;
      DONE:    state_d = bus.out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state_q)
      IDLE:    bus.in_ready  = 1'b1;
      DONE:    bus.out_valid = 1'b1;
      default: begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
      end
    endcase
  end

  // Operand shift registers, running carry and result/flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      op_q     <= 1'b0;
      carry_q  <= 1'b0;
      a_sign_q <= 1'b0;
      cnt_q    <= '0;
      s_q      <= '0;
      cout_q   <= 1'b0;
      v_q      <= 1'b0;
      z_q      <= 1'b1;
      n_q      <= 1'b0;
    end else if (accept_s) begin
      a_q      <= bus.A;
      b_q      <= bus.B;
      acc_q    <= '0;
      op_q     <= bus.Op;
      carry_q  <= (bus.Op == OP_SUB);
      a_sign_q <= bus.A[WIDTH-1];
      cnt_q    <= CW'(K - 1);
    end else if (state_q == RUN) begin
      a_q     <= a_q >> STEP;
      b_q     <= b_q >> STEP;
      acc_q   <= acc_next_s;
      carry_q <= sl_cout_s;
      cnt_q   <= cnt_q - CW'(1);
      if (last_s) begin
        s_q    <= res_s;
        cout_q <= sl_cout_s;
        v_q    <= v_next_s;
        z_q    <= (res_s == '0);
        n_q    <= res_s[WIDTH-1];
      end
    end
  end

  assign bus.S    = s_q;
  assign bus.Cout = cout_q;
  assign bus.V    = v_q;
  assign bus.Z    = z_q;
  assign bus.N    = n_q;

endmodule

// File: tb/tb_seq_addsub_unit.sv
// Self-checking bench for seq_addsub_unit: table vectors, scoreboard, random ops,
// backpressure, mid-operation reset and a WIDTH=16/STEP=4 instance.
module tb_seq_addsub_unit;

  typedef struct {
    logic [15:0] s;
    logic        cout;
    logic        v;
    logic        z;
    logic        n;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       op;
    exp_t       e;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  vec_t vecs[7];

  always #5 clk = ~clk;

  seq_addsub_unit_if #(.WIDTH(8))  bus8 ();
  seq_addsub_unit_if #(.WIDTH(16)) bus16 ();

  seq_addsub_unit #(.WIDTH(8), .STEP(1)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  seq_addsub_unit #(.WIDTH(16), .STEP(4)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus16)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t model8(input logic [7:0] a, input logic [7:0] b, input logic op);
    logic [8:0] sum;
    exp_t e;
    sum    = {1'b0, a} + {1'b0, (op ? ~b : b)} + {8'd0, op};
    e.s    = {8'd0, sum[7:0]};
    e.cout = sum[8];
    e.v    = op ? ((a[7] != b[7]) && (sum[7] != a[7]))
                : ((a[7] == b[7]) && (sum[7] != a[7]));
`ifdef ADDSUB_SAT_EN
    if (e.v) e.s = a[7] ? 16'h0080 : 16'h007F;
`endif
    e.z = (e.s == 16'h0000);
    e.n = e.s[7];
    return e;
  endfunction

  function automatic exp_t mk(input logic [7:0] s, input logic c, input logic v,
                              input logic z, input logic n);
    exp_t e;
    e.s = {8'd0, s}; e.cout = c; e.v = v; e.z = z; e.n = n;
    return e;
  endfunction

  task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic op,
                         input exp_t e, input int hold);
    int   lat;
    int   w;
    exp_t got;
    logic [11:0] held;
    w = 0;
    @(negedge clk);
    while (!bus8.in_ready && w < 30) begin @(negedge clk); w++; end
    check("in_ready_idle", bus8.in_ready, 1);
    bus8.A = a; bus8.B = b; bus8.Op = op; bus8.in_valid = 1'b1;
    bus8.out_ready = (hold == 0);
    sb.push_back(e);
    @(negedge clk);
    bus8.in_valid = 1'b0;
    bus8.A = 8'($urandom); bus8.B = 8'($urandom); bus8.Op = ~op;
    lat = 1;
    while (!bus8.out_valid && lat < 40) begin @(negedge clk); lat++; end
    check("latency8", lat, 9);
    got = sb.pop_front();
    check("S", bus8.S, got.s[7:0]);
    check("Cout", bus8.Cout, got.cout);
    check("V", bus8.V, got.v);
    check("Z", bus8.Z, got.z);
    check("N", bus8.N, got.n);
    if (hold > 0) begin
      held = {bus8.S, bus8.Cout, bus8.V, bus8.Z, bus8.N};
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check("hold_out_valid", bus8.out_valid, 1);
        check("hold_in_ready", bus8.in_ready, 0);
        check("hold_outputs", {bus8.S, bus8.Cout, bus8.V, bus8.Z, bus8.N}, held);
      end
      bus8.out_ready = 1'b1;
    end
    @(negedge clk);
    check("back_to_idle_in_ready", bus8.in_ready, 1);
    check("back_to_idle_out_valid", bus8.out_valid, 0);
  endtask

  task automatic run_op16(input logic [15:0] a, input logic [15:0] b, input logic op,
                          input logic [15:0] s, input logic [3:0] cvzn);
    int lat;
    int w;
    w = 0;
    @(negedge clk);
    while (!bus16.in_ready && w < 30) begin @(negedge clk); w++; end
    bus16.A = a; bus16.B = b; bus16.Op = op; bus16.in_valid = 1'b1;
    @(negedge clk);
    bus16.in_valid = 1'b0; bus16.A = 16'($urandom); bus16.B = 16'($urandom);
    lat = 1;
    while (!bus16.out_valid && lat < 40) begin @(negedge clk); lat++; end
    check("latency16", lat, 5);
    check("S16", bus16.S, s);
    check("CVZN16", {bus16.Cout, bus16.V, bus16.Z, bus16.N}, cvzn);
    @(negedge clk);
  endtask

  initial begin
    int   seen;
    exp_t e;
    logic [7:0] ra, rb;
    logic       rop;

    vecs[0] = '{8'h05, 8'h05, 1'b1, mk(8'h00, 1'b1, 1'b0, 1'b1, 1'b0)};
    vecs[1] = '{8'h00, 8'h01, 1'b1, mk(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1)};
    vecs[2] = '{8'hFF, 8'h01, 1'b0, mk(8'h00, 1'b1, 1'b0, 1'b1, 1'b0)};
    vecs[3] = '{8'h3C, 8'h5A, 1'b1, mk(8'hE2, 1'b0, 1'b0, 1'b0, 1'b1)};
`ifdef ADDSUB_SAT_EN
    vecs[4] = '{8'h7F, 8'h01, 1'b0, mk(8'h7F, 1'b0, 1'b1, 1'b0, 1'b0)};
    vecs[5] = '{8'h80, 8'h01, 1'b1, mk(8'h80, 1'b1, 1'b1, 1'b0, 1'b1)};
    vecs[6] = '{8'h80, 8'h80, 1'b0, mk(8'h80, 1'b1, 1'b1, 1'b0, 1'b1)};
`else
    vecs[4] = '{8'h7F, 8'h01, 1'b0, mk(8'h80, 1'b0, 1'b1, 1'b0, 1'b1)};
    vecs[5] = '{8'h80, 8'h01, 1'b1, mk(8'h7F, 1'b1, 1'b1, 1'b0, 1'b0)};
    vecs[6] = '{8'h80, 8'h80, 1'b0, mk(8'h00, 1'b1, 1'b1, 1'b1, 1'b0)};
`endif

    bus8.A = 8'h00; bus8.B = 8'h00; bus8.Op = 1'b0; bus8.in_valid = 1'b0; bus8.out_ready = 1'b1;
    bus16.A = 16'h0; bus16.B = 16'h0; bus16.Op = 1'b0; bus16.in_valid = 1'b0; bus16.out_ready = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_S", bus8.S, 8'h00);
    check("rst_CVZN", {bus8.Cout, bus8.V, bus8.Z, bus8.N}, 4'b0010);
    check("rst_out_valid", bus8.out_valid, 0);
    check("rst_S16", bus16.S, 16'h0000);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_release_in_ready", bus8.in_ready, 1);

    for (int i = 0; i < 7; i++) run_op8(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].e, 0);

    // backpressure on a table vector
    run_op8(vecs[3].a, vecs[3].b, vecs[3].op, vecs[3].e, 5);

    for (int i = 0; i < 6; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rop = 1'($urandom);
      run_op8(ra, rb, rop, model8(ra, rb, rop), (i == 2) ? 2 : 0);
    end

    // reset in the third RUN cycle discards the op
    @(negedge clk);
    bus8.A = 8'h12; bus8.B = 8'h34; bus8.Op = 1'b0; bus8.in_valid = 1'b1;
    @(negedge clk);
    bus8.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", bus8.out_valid, 0);
    check("midrst_S", bus8.S, 8'h00);
    check("midrst_Z", bus8.Z, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus8.out_valid) seen++;
    end
    check("midrst_no_output", seen, 0);
    check("midrst_in_ready", bus8.in_ready, 1);
    run_op8(8'h10, 8'h20, 1'b0, mk(8'h30, 1'b0, 1'b0, 1'b0, 1'b0), 0);

    run_op16(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 4'b1010);
`ifdef ADDSUB_SAT_EN
    run_op16(16'h7FFF, 16'h0001, 1'b0, 16'h7FFF, 4'b0100);
`else
    run_op16(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 4'b0101);
`endif
    run_op16(16'h1234, 16'h1234, 1'b1, 16'h0000, 4'b1010);

    check("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_addsub_unit.md
SEQ_ADDSUB_UNIT -- requirements
Module: seq_addsub_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (>=2).
REQ-002 SHALL have parameter STEP, default 1, bits processed per cycle; WIDTH % STEP == 0 required, elaboration error otherwise.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports A, B  input  WIDTH  operands.
REQ-006 SHALL have port Op  input  1  0 = add, 1 = subtract (A - B).
REQ-007 SHALL have ports in_valid input 1 and in_ready output 1 for the request handshake.
REQ-008 SHALL have port S  output  WIDTH  result.
REQ-009 SHALL have ports Cout, V, Z, N  output  1 each: carry out (no-borrow on subtract), signed overflow, zero, result MSB.
REQ-010 SHALL have ports out_valid output 1 and out_ready input 1 for the result handshake.

Function
REQ-011 SHALL implement the FSM IDLE -> RUN -> DONE -> IDLE.
REQ-012 SHALL assert in_ready only in IDLE; a transfer occurs when in_valid && in_ready, which latches A, B and Op, sets carry = Op, and moves to RUN.
REQ-013 SHALL compute, in RUN, one STEP-bit slice per cycle, LSB first, using A_slice + (Op ? ~B_slice : B_slice) + carry, and register the carry between slices.
REQ-014 SHALL remain in RUN for exactly K = WIDTH/STEP cycles, then enter DONE with out_valid = 1.
REQ-015 SHALL have a latency from the accept edge to the first cycle of out_valid of K+1 cycles: one accept cycle plus K RUN cycles.
REQ-016 SHALL hold S, Cout, V, Z and N stable while out_valid = 1 && out_ready = 0.
REQ-017 SHALL return to IDLE on out_ready in DONE, and SHALL not accept a new request in the same cycle, giving a throughput of one op per K+2 cycles.
REQ-018 SHALL define the flags as: Cout = final carry; V = carry into MSB XOR carry out of MSB; Z = (S == 0); N = S[WIDTH-1].
REQ-019 SHALL ignore A, B and Op changes outside the accept cycle.
REQ-020 SHALL assert out_valid in the first cycle of DONE even when out_ready is already high.
REQ-021 SHALL hold in_ready low in RUN and DONE, so in_valid asserted there has no effect.

Reset
REQ-022 SHALL, on rst_n low, immediately force the state to IDLE and set out_valid = 0, in_ready = 1 (from the first clk after release), S = 0, Cout = V = N = 0, Z = 1 and the carry register to 0.
REQ-023 SHALL, on reset during RUN or DONE, discard the in-flight operation and produce no output for it.

Configuration
REQ-024 SHALL use macro ADDSUB_SAT_EN; when it is defined, a result with V = 1 SHALL be replaced by signed saturation: 0x7F.. if A is non-negative, 0x80.. if A is negative.
REQ-025 SHALL, with ADDSUB_SAT_EN defined, keep V = 1 on a saturated result and recompute Z and N from the saturated S; Cout SHALL be unchanged.
REQ-026 SHALL, with ADDSUB_SAT_EN undefined, return a wrap-around result, and the saturation logic SHALL be absent.

Structure
REQ-027 SHALL place in the shared package addsub_pkg: the state enum (IDLE, RUN, DONE), the op encoding constants (OP_ADD = 0, OP_SUB = 1) and the parameter-legality check function.
REQ-028 SHALL contain one sub-module, addsub_slice: a combinational STEP-bit ripple of full adders with inputs a, b, cin, sub and outputs s, cout, cmsb (carry into the slice MSB).

Verification
REQ-029 SHALL cover, with WIDTH=8 and STEP=1: add 0x7F + 0x01 -> S=0x80, V=1, N=1, Cout=0, Z=0, out_valid at accept+9; with ADDSUB_SAT_EN -> S=0x7F, V=1, N=0.
REQ-030 SHALL cover: sub 0x05 - 0x05 -> S=0x00, Z=1, Cout=1, V=0.
REQ-031 SHALL cover: sub 0x00 - 0x01 -> S=0xFF, Cout=0, N=1, V=0; sub 0x80 - 0x01 -> S=0x7F, V=1 (with ADDSUB_SAT_EN -> S=0x80).
REQ-032 SHALL cover backpressure: out_ready held low 5 cycles -> outputs stable, in_ready=0 throughout; out_ready pulse -> IDLE next cycle.
REQ-033 SHALL cover reset mid-op: rst_n low at RUN cycle 3 -> out_valid=0 and in_ready=1 after release; the next op 0x10 + 0x20 -> S=0x30.
REQ-034 SHALL cover: WIDTH=16, STEP=4, add 0xFFFF + 0x0001 -> S=0x0000, Cout=1, Z=1, out_valid at accept+5.
